// File: rtl/cpu_bus_arbiter_if.sv
// Request/response handshakes of NUM_REQ masters plus the shared CPU register bus.
// Pure wiring, no latency of its own.
// Requesters hold req_valid until their req_ready pulse; the bus side has no backpressure.
interface cpu_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [16*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  CPURead;
  logic                  CPUWrite;
  logic [15:0]           CPUAddress;
  logic [31:0]           CPUWriteData;
  logic [31:0]           CPUReadData;

  // Arbiter view: consumes requests and read data, drives grants, responses and the bus.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, CPUReadData,
    output req_ready, rsp_valid, rsp_rdata, CPURead, CPUWrite, CPUAddress, CPUWriteData
  );

  // Requester / bus-slave view.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, CPUReadData,
    input  req_ready, rsp_valid, rsp_rdata, CPURead, CPUWrite, CPUAddress, CPUWriteData
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one CPU register bus among NUM_REQ masters, one txn in flight.
// Strobe 1 cycle after a request is seen in IDLE; response 2 cycles after (reads: +RD_LATENCY).
// Non-winners keep req_valid high and are only sampled while IDLE; no backpressure on responses.
module cpu_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 0
) (
  input logic              clk,
  input logic              resetn,
  cpu_bus_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      win_idx;
  logic               win_write;
  logic [2:0]         lat_cnt;
  logic [NUM_REQ-1:0] ready_q;
  logic [NUM_REQ-1:0] rsp_q;
  logic [31:0]        rdata_q;
  logic               cpu_rd_q;
  logic               cpu_wr_q;
  logic [15:0]        addr_q;
  logic [31:0]        wdata_q;

  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic               hi_vld;
  logic [IW-1:0]      hi_idx;
  logic [IW-1:0]      lo_idx;
  logic               pick_write;
  logic [15:0]        pick_addr;
  logic [31:0]        pick_wdata;

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest requester overall (wrap).
  always_comb begin
    pick_vld = 1'b0;
    hi_vld   = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        pick_vld = 1'b1;
        lo_idx   = IW'(i);
        if (IW'(i) >= rr_ptr) begin
          hi_vld = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  // Select the winner's command fields using constant slice positions.
  always_comb begin
    pick_write = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_write = bus.req_write[i];
        pick_addr  = bus.req_addr[16*i +: 16];
        pick_wdata = bus.req_wdata[32*i +: 32];
      end
    end
  end

  // Transaction FSM; every output is registered and the pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_idx   <= '0;
      win_write <= 1'b0;
      lat_cnt   <= '0;
      ready_q   <= '0;
      rsp_q     <= '0;
      rdata_q   <= '0;
      cpu_rd_q  <= 1'b0;
      cpu_wr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      ready_q  <= '0;
      rsp_q    <= '0;
      rdata_q  <= '0;
      cpu_rd_q <= 1'b0;
      cpu_wr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            win_idx   <= pick_idx;
            win_write <= pick_write;
            addr_q    <= pick_addr;
            wdata_q   <= pick_wdata;
            ready_q   <= ONE << pick_idx;
            cpu_wr_q  <= pick_write;
            cpu_rd_q  <= !pick_write;
            state     <= CMD;
          end
        end
        CMD: begin
          rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          if (win_write) begin
            rsp_q <= ONE << win_idx;
            state <= RESP;
          end else if (RD_LATENCY == 0) begin
            rsp_q   <= ONE << win_idx;
            rdata_q <= bus.CPUReadData;
            state   <= RESP;
          end else begin
            lat_cnt <= 3'(RD_LATENCY);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            rsp_q   <= ONE << win_idx;
            rdata_q <= bus.CPUReadData;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.rsp_valid    = rsp_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.CPURead      = cpu_rd_q;
  assign bus.CPUWrite     = cpu_wr_q;
  assign bus.CPUAddress   = addr_q;
  assign bus.CPUWriteData = wdata_q;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Two arbiter configurations (4 masters / read latency 2, and 2 masters / read latency 0)
// driven by directed scenarios then random traffic, checked every cycle against a
// transaction-timing reference model.
module tb_cpu_bus_arbiter;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cpu_bus_arbiter_if #(.NUM_REQ(4)) bus_a ();
  cpu_bus_arbiter_if #(.NUM_REQ(2)) bus_b ();

  cpu_bus_arbiter #(.NUM_REQ(4), .RD_LATENCY(2)) dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  cpu_bus_arbiter #(.NUM_REQ(2), .RD_LATENCY(0)) dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

  // Master-side stimulus, index 0 = dut_a, 1 = dut_b.
  logic [3:0]  m_valid [2];
  logic [3:0]  m_write [2];
  logic [15:0] m_addr  [2][4];
  logic [31:0] m_wdata [2][4];
  logic [31:0] rd_drv  [2];

  assign bus_a.req_valid   = m_valid[0];
  assign bus_a.req_write   = m_write[0];
  assign bus_a.req_addr    = {m_addr[0][3], m_addr[0][2], m_addr[0][1], m_addr[0][0]};
  assign bus_a.req_wdata   = {m_wdata[0][3], m_wdata[0][2], m_wdata[0][1], m_wdata[0][0]};
  assign bus_a.CPUReadData = rd_drv[0];
  assign bus_b.req_valid   = m_valid[1][1:0];
  assign bus_b.req_write   = m_write[1][1:0];
  assign bus_b.req_addr    = {m_addr[1][1], m_addr[1][0]};
  assign bus_b.req_wdata   = {m_wdata[1][1], m_wdata[1][0]};
  assign bus_b.CPUReadData = rd_drv[1];

  // Observed outputs widened to a common shape.
  logic [3:0]  o_ready [2];
  logic [3:0]  o_rsp   [2];
  logic        o_rd    [2];
  logic        o_wr    [2];
  logic [15:0] o_addr  [2];
  logic [31:0] o_wdata [2];
  logic [31:0] o_rdata [2];

  assign o_ready[0] = bus_a.req_ready;
  assign o_ready[1] = {2'b00, bus_b.req_ready};
  assign o_rsp[0]   = bus_a.rsp_valid;
  assign o_rsp[1]   = {2'b00, bus_b.rsp_valid};
  assign o_rd[0]    = bus_a.CPURead;
  assign o_rd[1]    = bus_b.CPURead;
  assign o_wr[0]    = bus_a.CPUWrite;
  assign o_wr[1]    = bus_b.CPUWrite;
  assign o_addr[0]  = bus_a.CPUAddress;
  assign o_addr[1]  = bus_b.CPUAddress;
  assign o_wdata[0] = bus_a.CPUWriteData;
  assign o_wdata[1] = bus_b.CPUWriteData;
  assign o_rdata[0] = bus_a.rsp_rdata;
  assign o_rdata[1] = bus_b.rsp_rdata;

  // Reference model state: per DUT, the edge of the last grant and when it may grant again.
  int          nreq [2] = '{4, 2};
  int          lat  [2] = '{2, 0};
  int          next_free [2];
  int          g_edge    [2];
  int          rr        [2];
  logic [1:0]  w_idx     [2];
  logic        w_wr      [2];
  logic [15:0] l_addr    [2];
  logic [31:0] l_wdata   [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Predict outputs right after clock edge 'cyc' from the inputs sampled at that edge.
  task automatic model_step(input int d);
    logic [3:0]  e_ready;
    logic [3:0]  e_rsp;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_rdata;
    string       nm;
    int          idx;
    e_ready = '0;
    e_rsp   = '0;
    e_rd    = 1'b0;
    e_wr    = 1'b0;
    e_rdata = '0;
    nm      = (d == 0) ? "a" : "b";
    if (!resetn) begin
      next_free[d] = cyc + 1;
      g_edge[d]    = -100;
      rr[d]        = 0;
      l_addr[d]    = '0;
      l_wdata[d]   = '0;
    end else begin
      if (cyc >= next_free[d] && m_valid[d] != 4'b0000) begin
        for (int k = nreq[d] - 1; k >= 0; k--) begin
          idx = (rr[d] + k) % nreq[d];
          if (m_valid[d][idx[1:0]]) w_idx[d] = idx[1:0];
        end
        g_edge[d]    = cyc;
        w_wr[d]      = m_write[d][w_idx[d]];
        l_addr[d]    = m_addr[d][w_idx[d]];
        l_wdata[d]   = m_wdata[d][w_idx[d]];
        rr[d]        = (int'(w_idx[d]) + 1) % nreq[d];
        next_free[d] = cyc + 3 + (w_wr[d] ? 0 : lat[d]);
      end
      if (cyc == g_edge[d]) begin
        e_ready = 4'b0001 << w_idx[d];
        e_wr    = w_wr[d];
        e_rd    = !w_wr[d];
      end
      if (g_edge[d] >= 0 && cyc == g_edge[d] + 1 + (w_wr[d] ? 0 : lat[d])) begin
        e_rsp   = 4'b0001 << w_idx[d];
        e_rdata = w_wr[d] ? 32'h0 : rd_drv[d];
      end
    end
    check_eq({nm, ".req_ready"}, 32'(o_ready[d]), 32'(e_ready));
    check_eq({nm, ".CPURead"}, 32'(o_rd[d]), 32'(e_rd));
    check_eq({nm, ".CPUWrite"}, 32'(o_wr[d]), 32'(e_wr));
    check_eq({nm, ".CPUAddress"}, 32'(o_addr[d]), 32'(l_addr[d]));
    check_eq({nm, ".CPUWriteData"}, o_wdata[d], l_wdata[d]);
    check_eq({nm, ".rsp_valid"}, 32'(o_rsp[d]), 32'(e_rsp));
    check_eq({nm, ".rsp_rdata"}, o_rdata[d], e_rdata);
  endtask

  // One clock: sample #1 after the edge, run the model, then masters drop accepted requests.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_step(0);
    model_step(1);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        if (o_ready[d][i]) m_valid[d][i] = 1'b0;
  endtask

  task automatic set_req(input int d, input int i, input logic wr, input logic [15:0] a,
                         input logic [31:0] wd);
    m_write[d][i] = wr;
    m_addr[d][i]  = a;
    m_wdata[d][i] = wd;
    m_valid[d][i] = 1'b1;
  endtask

  // Idle masters re-roll their command each cycle and raise a request with probability pct.
  task automatic rand_masters(input int pct);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < nreq[d]; i++)
        if (!m_valid[d][i]) begin
          m_write[d][i] = 1'($urandom_range(0, 1));
          m_addr[d][i]  = 16'($urandom);
          m_wdata[d][i] = $urandom;
          if ($urandom_range(0, 99) < pct) m_valid[d][i] = 1'b1;
        end
  endtask

  logic [3:0] gq[$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      next_free[d] = 0;
      g_edge[d]    = -100;
      rr[d]        = 0;
      w_idx[d]     = '0;
      w_wr[d]      = 1'b0;
      l_addr[d]    = '0;
      l_wdata[d]   = '0;
      rd_drv[d]    = '0;
      m_write[d]   = '0;
      for (int i = 0; i < 4; i++) begin
        m_addr[d][i]  = 16'($urandom);
        m_wdata[d][i] = $urandom;
      end
    end

    // Reset held with every master requesting: everything stays 0.
    resetn     = 1'b0;
    m_valid[0] = 4'b1111;
    m_valid[1] = 4'b0011;
    repeat (4) tick();

    // Continuous contention on masters 0 and 1 from reset release: grants alternate.
    m_valid[0] = 4'b0011;
    resetn     = 1'b1;
    for (int c = 0; c < 24; c++) begin
      rd_drv[0] = $urandom;
      rd_drv[1] = $urandom;
      tick();
      if (o_ready[0] != 4'b0000) gq.push_back(o_ready[0]);
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 2; i++)
          if (!m_valid[d][i]) set_req(d, i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
    end
    check_eq("t4_grant_count", 32'(gq.size() >= 4), 32'd1);
    foreach (gq[j]) check_eq("t4_order", 32'(gq[j]), (j % 2 == 1) ? 32'd2 : 32'd1);
    m_valid[0] = '0;
    m_valid[1] = '0;
    repeat (8) tick();

    // Single write by master 0.
    set_req(0, 0, 1'b1, 16'h3004, 32'hDEADBEEF);
    set_req(1, 0, 1'b1, 16'h3004, 32'hDEADBEEF);
    tick();
    check_eq("t2_strobe", 32'(o_wr[0]), 32'd1);
    check_eq("t2_addr", 32'(o_addr[0]), 32'h3004);
    check_eq("t2_wdata", o_wdata[0], 32'hDEADBEEF);
    check_eq("t2_ready", 32'(o_ready[0]), 32'h1);
    tick();
    check_eq("t2_rsp", 32'(o_rsp[0]), 32'h1);
    check_eq("t2_rdata", o_rdata[0], 32'h0);
    repeat (4) tick();

    // Read by master 1; slave data is valid only RD_LATENCY cycles after the strobe.
    rd_drv[0] = 32'hEDCBA987;
    set_req(0, 1, 1'b0, 16'h5000, 32'h0);
    set_req(1, 1, 1'b0, 16'h5000, 32'h0);
    tick();
    check_eq("t3_strobe", 32'(o_rd[0]), 32'd1);
    tick();
    tick();
    rd_drv[0] = 32'h12345678;
    tick();
    check_eq("t3_rsp", 32'(o_rsp[0]), 32'h2);
    check_eq("t3_rdata", o_rdata[0], 32'h12345678);
    rd_drv[0] = 32'h0BADF00D;
    repeat (4) tick();

    // Wrap: after master 2 is granted, requests {0,2} give 0 first, then 2.
    set_req(0, 2, 1'b1, 16'h2000, 32'h22222222);
    tick();
    repeat (4) tick();
    set_req(0, 0, 1'b1, 16'h0100, 32'h00000001);
    set_req(0, 2, 1'b1, 16'h0200, 32'h00000002);
    tick();
    check_eq("t6_first", 32'(o_ready[0]), 32'h1);
    repeat (2) tick();
    tick();
    check_eq("t6_second", 32'(o_ready[0]), 32'h4);
    repeat (4) tick();

    // Reset while a read waits: no response, pointer returns to 0.
    set_req(0, 0, 1'b0, 16'h5004, 32'h0);
    tick();
    check_eq("t5_strobe", 32'(o_rd[0]), 32'd1);
    tick();
    resetn = 1'b0;
    tick();
    check_eq("t5_no_rsp", 32'(o_rsp[0]), 32'h0);
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("t5_quiet", 32'(o_rsp[0]), 32'h0);
    end
    set_req(0, 0, 1'b1, 16'h0A00, 32'hA0A0A0A0);
    set_req(0, 1, 1'b1, 16'h0B00, 32'hB0B0B0B0);
    tick();
    check_eq("t5_rr_reset", 32'(o_ready[0]), 32'h1);
    repeat (8) tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rd_drv[0] = $urandom;
      rd_drv[1] = $urandom;
      rand_masters(25);
      resetn = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    resetn     = 1'b1;
    m_valid[0] = '0;
    m_valid[1] = '0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
